// File: rtl/lmsm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lmsm_pkg
// Shared definitions for the LM/SM register-list sequencer: sequencer state
// encoding, default sizes, and the controller state IDs of the LM/SM loop
// states that drive the sequencer's start/step inputs.
// No ports (package).
// -----------------------------------------------------------------------------
package lmsm_pkg;

    localparam int NREG_DEF = 8;   // register bitmap width / number of GPRs
    localparam int AW_DEF   = 16;  // memory address width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DONE   = 2'b10
    } lmsm_state_t;

    // Controller state IDs for the LM/SM loop. The *_SETUP states raise
    // `start`; the *_XFER states raise `step` once their transfer completes.
    localparam logic [4:0] CS_LM_SETUP = 5'd10;
    localparam logic [4:0] CS_LM_XFER  = 5'd11;
    localparam logic [4:0] CS_SM_SETUP = 5'd12;
    localparam logic [4:0] CS_SM_XFER  = 5'd13;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer_if
// Handshake/bus bundle between the controller/datapath (master) and the LM/SM
// sequencer (slave).
//   master drives : start, ir_list, base_addr, step
//   slave drives  : busy, valid, reg_idx, mem_addr, last, done, xfer_count
// -----------------------------------------------------------------------------
interface lmsm_sequencer_if
    import lmsm_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
);

    logic            start;
    logic [NREG-1:0] ir_list;
    logic [AW-1:0]   base_addr;
    logic            step;

    logic            busy;
    logic            valid;
    logic [2:0]      reg_idx;
    logic [AW-1:0]   mem_addr;
    logic            last;
    logic            done;
    logic [3:0]      xfer_count;

    modport master (
        output start, ir_list, base_addr, step,
        input  busy, valid, reg_idx, mem_addr, last, done, xfer_count
    );

    modport slave (
        input  start, ir_list, base_addr, step,
        output busy, valid, reg_idx, mem_addr, last, done, xfer_count
    );

endinterface

// File: rtl/lmsm_sequencer_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
// Combinational lowest-set-bit encoder for an 8-bit register bitmap.
// Ports:
//   vec     in  8 : bitmap to encode
//   idx     out 3 : index of the lowest set bit (0 when vec is empty)
//   one_hot out 1 : exactly one bit of vec is set
//   zero    out 1 : vec is all zeros
// -----------------------------------------------------------------------------
module prio_enc8 (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       one_hot,
    output logic       zero
);

    // Scan from the top down so the lowest set bit is the final assignment.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves it unassigned would infer a latch.
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign zero    = (vec == 8'd0);
    // x & (x-1) clears the lowest set bit; nothing left means a single bit.
    assign one_hot = !zero && ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
// Register-list sequencer for LM/SM. Walks the IR[7:0] bitmap from R0 upward,
// presenting one register index and one ascending memory word address per
// transfer, and signals the end of the list with a one-cycle `done` pulse.
// All state changes on the falling clock edge, in step with the controller.
// Ports:
//   clk      in  1 : clock (falling-edge active)
//   proc_rst in  1 : asynchronous active-low reset
//   bus      slave modport of lmsm_sequencer_if:
//            start/ir_list/base_addr/step in; busy/valid/reg_idx/mem_addr/
//            last/done/xfer_count out
// -----------------------------------------------------------------------------
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            proc_rst,
    lmsm_sequencer_if.slave bus
);

    lmsm_state_t     state;
    logic [NREG-1:0] pending;       // registers still to be transferred
    logic [AW-1:0]   addr;          // address of the current transfer
    logic [3:0]      xfer_count_q;
    logic            busy_q;
    logic            valid_q;
    logic            done_q;

    logic [2:0]      enc_idx;
    logic            enc_one_hot;
    logic            enc_zero;

    // The encoder is fixed at 8 bits, matching the IR[7:0] register bitmap.
    prio_enc8 u_enc (
        .vec     (pending),
        .idx     (enc_idx),
        .one_hot (enc_one_hot),
        .zero    (enc_zero)
    );

    always_ff @(negedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            state        <= ST_IDLE;
            pending      <= '0;
            addr         <= '0;
            xfer_count_q <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every branch below reads the pre-edge values of the registers.
            case (state)
                ST_IDLE: begin
                    // step is simply not looked at here, so start wins a collision.
                    if (bus.start) begin
                        pending      <= bus.ir_list;
                        addr         <= bus.base_addr;
                        xfer_count_q <= '0;
                        busy_q       <= 1'b1;
                        if (bus.ir_list == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_ACTIVE;
                            valid_q <= 1'b1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (bus.step) begin
                        pending      <= pending & (pending - NREG'(1));
                        addr         <= addr + AW'(1);
                        xfer_count_q <= xfer_count_q + 4'd1;
                        // enc_zero cannot occur in ACTIVE; treating it as the
                        // final step keeps the FSM from ever stalling there.
                        if (enc_one_hot || enc_zero) begin
                            state   <= ST_DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end

                default: begin
                    state   <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Transfer outputs read as zero whenever no transfer is being presented.
    assign bus.busy       = busy_q;
    assign bus.valid      = valid_q;
    assign bus.reg_idx    = valid_q ? enc_idx : 3'd0;
    assign bus.mem_addr   = valid_q ? addr : '0;
    assign bus.last       = valid_q & enc_one_hot;
    assign bus.done       = done_q;
    assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lmsm_sequencer
// Self-checking bench for lmsm_sequencer. A queue-based reference model of the
// register list is compared against every DUT output on each rising edge
// (the DUT updates on falling edges); directed sequences add hand-computed
// literal expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_lmsm_sequencer;
    import lmsm_pkg::*;

    logic clk      = 1'b0;
    logic proc_rst = 1'b0;

    always #5 clk = ~clk;

    lmsm_sequencer_if bus ();

    lmsm_sequencer dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Remaining transfers are a queue of register numbers, lowest first.
    int          m_q[$];
    logic [15:0] m_addr = 16'h0;
    int          m_cnt  = 0;
    bit          m_done = 1'b0;

    always @(negedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            m_q.delete();
            m_addr = 16'h0;
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            if (bus.step) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 16'd1;
                m_cnt  = m_cnt + 1;
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end else if (bus.start) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.ir_list[i]) m_q.push_back(i);
            end
            m_addr = bus.base_addr;
            m_cnt  = 0;
            m_done = (m_q.size() == 0);
        end
    end

    logic        exp_valid;
    logic        exp_busy;
    logic        exp_last;
    logic [2:0]  exp_idx;
    logic [15:0] exp_addr;
    logic [3:0]  exp_cnt;

    always @(posedge clk) begin
        if (proc_rst) begin
            exp_valid = (m_q.size() > 0);
            exp_busy  = exp_valid || m_done;
            exp_last  = (m_q.size() == 1);
            exp_idx   = 3'd0;
            exp_addr  = 16'h0;
            if (exp_valid) begin
                exp_idx  = 3'(m_q[0]);
                exp_addr = m_addr;
            end
            exp_cnt = 4'(m_cnt);
            check("model_busy",       bus.busy,       exp_busy);
            check("model_valid",      bus.valid,      exp_valid);
            check("model_reg_idx",    bus.reg_idx,    exp_idx);
            check("model_mem_addr",   bus.mem_addr,   exp_addr);
            check("model_last",       bus.last,       exp_last);
            check("model_done",       bus.done,       m_done);
            check("model_xfer_count", bus.xfer_count, exp_cnt);
        end
    end

    // ---------------- directed sequences ----------------
    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  bus.busy,       0);
        check({tag, "_valid"}, bus.valid,      0);
        check({tag, "_idx"},   bus.reg_idx,    0);
        check({tag, "_addr"},  bus.mem_addr,   0);
        check({tag, "_last"},  bus.last,       0);
        check({tag, "_done"},  bus.done,       0);
        check({tag, "_cnt"},   bus.xfer_count, 0);
    endtask

    // Start (with step also high, which must be dropped) and step every cycle.
    // idx_lit packs the expected register numbers, 3 bits each, first at LSB.
    task automatic walk(input logic [7:0] ir, input logic [15:0] base,
                        input int n, input logic [23:0] idx_lit);
        logic [15:0] ea;
        bus.start     = 1'b1;
        bus.ir_list   = ir;
        bus.base_addr = base;
        bus.step      = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            ea = base + 16'(k);
            check("walk_valid", bus.valid,    1);
            check("walk_idx",   bus.reg_idx,  idx_lit[3*k +: 3]);
            check("walk_addr",  bus.mem_addr, ea);
            check("walk_last",  bus.last,     (k == n - 1));
            check("walk_done",  bus.done,     0);
        end
        @(posedge clk); #1;
        bus.step = 1'b0;
        check("walk_end_done",  bus.done,       1);
        check("walk_end_valid", bus.valid,      0);
        check("walk_end_busy",  bus.busy,       1);
        check("walk_end_cnt",   bus.xfer_count, n);
        @(posedge clk); #1;
        check("walk_idle_done", bus.done,       0);
        check("walk_idle_busy", bus.busy,       0);
        check("walk_idle_cnt",  bus.xfer_count, n);
    endtask

    task automatic empty_list();
        bus.start     = 1'b1;
        bus.ir_list   = 8'h00;
        bus.base_addr = 16'h5555;
        bus.step      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        check("empty_done",  bus.done,       1);
        check("empty_valid", bus.valid,      0);
        check("empty_busy",  bus.busy,       1);
        check("empty_cnt",   bus.xfer_count, 0);
        check("empty_addr",  bus.mem_addr,   0);
        @(posedge clk); #1;
        check("empty_done2",  bus.done,  0);
        check("empty_busy2",  bus.busy,  0);
        check("empty_valid2", bus.valid, 0);
    endtask

    task automatic stall_test();
        bus.start     = 1'b1;
        bus.ir_list   = 8'h18;
        bus.base_addr = 16'h1234;
        bus.step      = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("stall_idx0",  bus.reg_idx,  3);
        check("stall_addr0", bus.mem_addr, 16'h1234);
        check("stall_last0", bus.last,     0);
        repeat (3) begin
            @(posedge clk); #1;
            check("stall_hold_valid", bus.valid,    1);
            check("stall_hold_idx",   bus.reg_idx,  3);
            check("stall_hold_addr",  bus.mem_addr, 16'h1234);
            check("stall_hold_cnt",   bus.xfer_count, 0);
        end
        bus.step = 1'b1;
        @(posedge clk); #1;
        check("stall_idx1",  bus.reg_idx,  4);
        check("stall_addr1", bus.mem_addr, 16'h1235);
        check("stall_last1", bus.last,     1);
        @(posedge clk); #1;
        bus.step = 1'b0;
        check("stall_done", bus.done,       1);
        check("stall_cnt",  bus.xfer_count, 2);
        @(posedge clk); #1;
    endtask

    task automatic collision_test();
        bus.start     = 1'b1;
        bus.ir_list   = 8'h06;
        bus.base_addr = 16'h0010;
        bus.step      = 1'b0;
        @(posedge clk); #1;
        check("coll_idx0", bus.reg_idx, 1);
        // Competing start during ACTIVE must be ignored.
        bus.start     = 1'b1;
        bus.ir_list   = 8'h01;
        bus.base_addr = 16'h0099;
        bus.step      = 1'b1;
        @(posedge clk); #1;
        check("coll_idx1",  bus.reg_idx,  2);
        check("coll_addr1", bus.mem_addr, 16'h0011);
        check("coll_last1", bus.last,     1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.step  = 1'b0;
        check("coll_done", bus.done,       1);
        check("coll_cnt",  bus.xfer_count, 2);
        @(posedge clk); #1;
        check("coll_idle", bus.busy, 0);
    endtask

    task automatic reset_test();
        bus.start     = 1'b1;
        bus.ir_list   = 8'hE0;
        bus.base_addr = 16'h0300;
        bus.step      = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("rst_idx_before",  bus.reg_idx,  5);
        check("rst_addr_before", bus.mem_addr, 16'h0300);
        #2;
        proc_rst = 1'b0;
        #1;
        check_all_zero("rst_now");
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_no_done", bus.done, 0);
            check("rst_no_busy", bus.busy, 0);
        end
        proc_rst      = 1'b1;
        bus.start     = 1'b1;
        bus.ir_list   = 8'h02;
        bus.base_addr = 16'h0020;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("rst_new_valid", bus.valid,      1);
        check("rst_new_idx",   bus.reg_idx,    1);
        check("rst_new_addr",  bus.mem_addr,   16'h0020);
        check("rst_new_last",  bus.last,       1);
        check("rst_new_cnt",   bus.xfer_count, 0);
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
        check("rst_new_done", bus.done,       1);
        check("rst_new_cnt2", bus.xfer_count, 1);
        @(posedge clk); #1;
        check("rst_new_idle", bus.busy, 0);
    endtask

    task automatic random_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (!proc_rst) proc_rst = 1'b1;
            bus.start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       bus.ir_list = 8'h00;
                1:       bus.ir_list = 8'hFF;
                default: bus.ir_list = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0)
                bus.base_addr = 16'hFFF0 + 16'($urandom_range(0, 15));
            else
                bus.base_addr = 16'($urandom);
            bus.step = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                proc_rst = 1'b0;
                #1;
                check("rnd_rst_busy",  bus.busy,       0);
                check("rnd_rst_valid", bus.valid,      0);
                check("rnd_rst_done",  bus.done,       0);
                check("rnd_rst_cnt",   bus.xfer_count, 0);
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.ir_list   = 8'h00;
        bus.base_addr = 16'h0000;
        #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        proc_rst = 1'b1;

        walk(8'hA5, 16'h0040, 4, 24'h000F50);    // R0, R2, R5, R7
        empty_list();
        walk(8'hFF, 16'hFFFE, 8, 24'hFAC688);    // R0..R7, address wraps
        stall_test();
        collision_test();
        reset_test();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
